// File: rtl/vector_alu_sequencer.sv
// ============================================================================
// Module      : vector_alu_sequencer
// Description : Steps one shared scalar ALU across LANES vector elements,
//               one lane per clock. Optional macro VSEQ_DIVZERO_FLAG_EN adds
//               divide-by-zero saturation and the divz flag port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_alu_sequencer #(
    parameter  int N     = 16,
    parameter  int LANES = 4,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2:0]           op,
    input  logic [N*LANES-1:0]   va,
    input  logic [N*LANES-1:0]   vb,
    input  logic [LANES-1:0]     mask,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [N*LANES-1:0]   vresult,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic [2:0]           alu_f,
    input  logic [N-1:0]         alu_result
`ifdef VSEQ_DIVZERO_FLAG_EN
    ,
    output logic [LANES-1:0]     divz
`endif
);

    localparam logic [LW-1:0] c_last_lane = LW'(LANES - 1);
    localparam logic [2:0]    c_op_idle   = 3'b010;
`ifdef VSEQ_DIVZERO_FLAG_EN
    localparam logic [2:0]    c_op_div    = 3'b100;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [LW-1:0]     r_lane;
    logic [2:0]        r_op;
    logic [LANES-1:0]  r_mask;
    logic [N-1:0]      r_a   [LANES];
    logic [N-1:0]      r_b   [LANES];
    logic [N-1:0]      r_res [LANES];

    logic              w_last;
    logic              w_accept;
    logic              w_write;
    logic [N-1:0]      w_lane_val;
`ifdef VSEQ_DIVZERO_FLAG_EN
    logic [LANES-1:0]  r_divz;
    logic              w_divzero;
`endif

    assign w_last   = (r_lane == c_last_lane);
    assign w_accept = (r_state == S_IDLE) && start;
    // An aborted RUN cycle must not commit its lane.
    assign w_write  = (r_state == S_RUN) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN: begin
                if (abort)       w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_lane_val = r_mask[r_lane] ? alu_result : r_a[r_lane];
`ifdef VSEQ_DIVZERO_FLAG_EN
        w_divzero  = (r_op == c_op_div) && r_mask[r_lane] && (r_b[r_lane] == '0);
        if (w_divzero) w_lane_val = '1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane <= '0;
            r_op   <= '0;
            r_mask <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_res[i] <= '0;
            end
`ifdef VSEQ_DIVZERO_FLAG_EN
            r_divz <= '0;
`endif
        end else if (w_accept) begin
            r_lane <= '0;
            r_op   <= op;
            r_mask <= mask;
            for (int i = 0; i < LANES; i++) begin
                r_a[i] <= va[i*N +: N];
                r_b[i] <= vb[i*N +: N];
            end
`ifdef VSEQ_DIVZERO_FLAG_EN
            r_divz <= '0;
`endif
        end else if (w_write) begin
            r_res[r_lane] <= w_lane_val;
            // Counter parks on the last lane so non-power-of-two LANES never wraps.
            if (!w_last) r_lane <= r_lane + 1'b1;
`ifdef VSEQ_DIVZERO_FLAG_EN
            if (w_divzero) r_divz[r_lane] <= 1'b1;
`endif
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_pack
            assign vresult[g*N +: N] = r_res[g];
        end
    endgenerate

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign alu_a = busy ? r_a[r_lane] : '0;
    assign alu_b = busy ? r_b[r_lane] : '0;
    assign alu_f = busy ? r_op        : c_op_idle;
`ifdef VSEQ_DIVZERO_FLAG_EN
    assign divz  = r_divz;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vector_alu_sequencer.sv
// ============================================================================
// Module      : tb_vector_alu_sequencer
// Description : Self-checking bench: directed plan cases plus random vector
//               operations against a lane-by-lane reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_alu_sequencer;

    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int W     = N * LANES;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [2:0]       op;
    logic [W-1:0]     va;
    logic [W-1:0]     vb;
    logic [LANES-1:0] mask;
    logic             ready;
    logic             busy;
    logic             done;
    logic [W-1:0]     vresult;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [2:0]       alu_f;
    logic [N-1:0]     alu_result;
`ifdef VSEQ_DIVZERO_FLAG_EN
    logic [LANES-1:0] divz;
    logic [LANES-1:0] model_dz;
`endif

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] model_res;

    vector_alu_sequencer #(.N(N), .LANES(LANES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .op         (op),
        .va         (va),
        .vb         (vb),
        .mask       (mask),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .vresult    (vresult),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_result (alu_result)
`ifdef VSEQ_DIVZERO_FLAG_EN
        ,
        .divz       (divz)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in scalar ALU; divide by zero returns a recognisable marker.
    function automatic logic [N-1:0] alu_fn(input logic [2:0] f, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [2*N-1:0] prod;
        prod = a * b;
        case (f)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return prod[N-1:0];
            3'd4: return (b == '0) ? N'(16'h0BAD) : a / b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_f, alu_a, alu_b);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] lane_of(input logic [W-1:0] v, input int i);
        return v[i*N +: N];
    endfunction

    // One vector operation; abort_lane >= LANES means no abort.
    // Entered and left at one time unit after a rising edge with the DUT idle.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [LANES-1:0] m, input int abort_lane);
        logic [W-1:0] nres;
        logic [N-1:0] v;
        nres = model_res;
        check("idle_ready", {63'd0, ready}, 64'd1);
        op = o; va = a; vb = b; mask = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef VSEQ_DIVZERO_FLAG_EN
        model_dz = '0;
`endif
        // Scramble inputs: the latched copies must be unaffected.
        op = 3'($urandom); va = {$urandom, $urandom}; vb = {$urandom, $urandom};
        mask = LANES'($urandom);
        for (int k = 0; k < LANES; k++) begin
            check("run_state", {61'd0, ready, busy, done}, 64'b010);
            check("alu_a", {48'd0, alu_a}, {48'd0, lane_of(a, k)});
            check("alu_b", {48'd0, alu_b}, {48'd0, lane_of(b, k)});
            check("alu_f", {61'd0, alu_f}, {61'd0, o});
            start = 1'($urandom);
            abort = (k == abort_lane);
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (k == abort_lane) begin
                check("abort_state", {61'd0, ready, busy, done}, 64'b100);
                check("abort_vres", vresult, nres);
`ifdef VSEQ_DIVZERO_FLAG_EN
                check("abort_divz", {60'd0, divz}, {60'd0, model_dz});
`endif
                model_res = nres;
                return;
            end
            v = m[k] ? alu_fn(o, lane_of(a, k), lane_of(b, k)) : lane_of(a, k);
`ifdef VSEQ_DIVZERO_FLAG_EN
            if (o == 3'b100 && m[k] && lane_of(b, k) == '0) begin
                v = '1;
                model_dz[k] = 1'b1;
            end
`endif
            nres[k*N +: N] = v;
            check("lane_vres", vresult, nres);
        end
        check("done_state", {61'd0, ready, busy, done}, 64'b001);
`ifdef VSEQ_DIVZERO_FLAG_EN
        check("done_divz", {60'd0, divz}, {60'd0, model_dz});
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("post_state", {61'd0, ready, busy, done}, 64'b100);
        check("post_vres", vresult, nres);
        model_res = nres;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; va = '0; vb = '0; mask = '0;
        model_res = '0;
`ifdef VSEQ_DIVZERO_FLAG_EN
        model_dz = '0;
`endif
        #2;
        check("rst_state", {61'd0, ready, busy, done}, 64'b100);
        check("rst_vres", vresult, 64'd0);
        check("rst_alu", {29'd0, alu_a, alu_b, alu_f}, {29'd0, 16'd0, 16'd0, 3'b010});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'b000, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd40, 16'd30, 16'd20, 16'd10},
               4'b1111, LANES);
        check("add_vec", vresult, {16'd44, 16'd33, 16'd22, 16'd11});

        run_op(3'b011, {4{16'd3}}, {16'd8, 16'd6, 16'd4, 16'd2}, 4'b0101, LANES);
        check("mul_vec", vresult, {16'd3, 16'd18, 16'd3, 16'd6});

        run_op(3'b000, {4{16'd9}}, {4{16'd0}}, 4'b0000, LANES);
        run_op(3'b000, {4{16'd1}}, {4{16'd1}}, 4'b1111, 2);
        check("abort_vec", vresult, {16'd9, 16'd9, 16'd2, 16'd2});
        // Abort on the last lane takes priority over going to DONE.
        run_op(3'b001, {4{16'd7}}, {4{16'd2}}, 4'b1111, LANES - 1);
        check("abort_last_vec", vresult, {16'd9, 16'd5, 16'd5, 16'd5});
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_noop", {61'd0, ready, busy, done}, 64'b100);

        run_op(3'b100, {4{16'd8}}, {16'd0, 16'd4, 16'd0, 16'd2}, 4'b1111, LANES);
`ifdef VSEQ_DIVZERO_FLAG_EN
        check("div_vec", vresult, {16'hFFFF, 16'd2, 16'hFFFF, 16'd4});
        check("div_flags", {60'd0, divz}, 64'b1010);
`else
        check("div_vec", vresult, {16'h0BAD, 16'd2, 16'h0BAD, 16'd4});
`endif

        // Reset in the middle of RUN.
        op = 3'b000; va = {4{16'd5}}; vb = {4{16'd5}}; mask = '1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_state", {61'd0, ready, busy, done}, 64'b100);
        check("midrst_vres", vresult, 64'd0);
        check("midrst_alu_f", {61'd0, alu_f}, {61'd0, 3'b010});
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_res = '0;
        @(posedge clk); #1;
        run_op(3'b000, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd1}, 4'b1111,
               LANES);
        check("postrst_vec", vresult, {16'd5, 16'd4, 16'd3, 16'd2});

        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] rb;
            rb = {$urandom, $urandom};
            for (int i = 0; i < LANES; i++) if ($urandom_range(0, 3) == 0) rb[i*N +: N] = '0;
            run_op(3'($urandom), {$urandom, $urandom}, rb, LANES'($urandom),
                   int'($urandom_range(0, 2 * LANES)));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
